// File: rtl/i2c_master_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_master_arbiter
//
// Round-robin arbiter that lets NUM_REQ requesters share one I2C master
// command port. One transaction is in flight at a time: the winner's command
// is captured, issued with a single start_trans_o pulse, and held on the
// command outputs until the master drops busy_i again.
//
// Optional feature (build macro I2C_ARB_TIMEOUT_EN): a watchdog aborts a
// transaction that has spent TIMEOUT_CYCLES cycles in WAIT_BUSY/WAIT_DONE.
// It then finishes with done_o and error_o. Without the macro there is no
// counter, the wait states wait forever, and error_o is tied low.
//
// Ports
//   clk_i, rst_i            system clock, async active-high reset
//   req_i                   per-requester request level
//   req_read_i              per-requester 1=read / 0=write
//   req_dev_addr_i          packed device addresses, requester k at slice k
//   req_dev_reg_addr_i      packed register addresses
//   req_wr_data_i           packed write data
//   ack_o                   1-cycle pulse, command of requester k captured
//   done_o                  1-cycle pulse, transaction of requester k finished
//   read_data_o             read data, valid with done_o, held until next read
//   error_o                 1-cycle pulse with done_o on a watchdog abort
//   start_trans_o, read_o, dev_addr_o, dev_reg_addr_o, wr_data_o
//                           command port to the I2C master
//   read_data_i, busy_i     status from the I2C master
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for a request while the master is not busy
// ISSUE     | start_trans_o/ack_o high for one cycle, command on outputs
// WAIT_BUSY | waiting for the master to raise busy_i
// WAIT_DONE | waiting for busy_i to fall, then capture read data
// DONE      | done_o pulse to the owner, back to IDLE
// ---------------------------------------------------------------------------
module i2c_master_arbiter #(
    parameter int NUM_REQ            = 4,
    parameter int DEV_ADDR_WIDTH     = 7,
    parameter int DEV_REG_ADDR_WIDTH = 8,
    parameter int DATA_WIDTH         = 8,
    parameter int TIMEOUT_CYCLES     = 65535
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NUM_REQ-1:0]                     req_i,
    input  logic [NUM_REQ-1:0]                     req_read_i,
    input  logic [NUM_REQ*DEV_ADDR_WIDTH-1:0]      req_dev_addr_i,
    input  logic [NUM_REQ*DEV_REG_ADDR_WIDTH-1:0]  req_dev_reg_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]          req_wr_data_i,
    output logic [NUM_REQ-1:0]                     ack_o,
    output logic [NUM_REQ-1:0]                     done_o,
    output logic [DATA_WIDTH-1:0]                  read_data_o,
    output logic                                   error_o,
    output logic                                   start_trans_o,
    output logic                                   read_o,
    output logic [DEV_ADDR_WIDTH-1:0]              dev_addr_o,
    output logic [DEV_REG_ADDR_WIDTH-1:0]          dev_reg_addr_o,
    output logic [DATA_WIDTH-1:0]                  wr_data_o,
    input  logic [DATA_WIDTH-1:0]                  read_data_i,
    input  logic                                   busy_i
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    logic [2:0]         state;
    logic [PTR_W-1:0]   ptr;
    logic [NUM_REQ-1:0] owner;

    // Round-robin pick: first requester at or above the pointer, otherwise
    // the lowest-numbered one (wrap-around).
    logic                          sel_found;
    int                            sel_k;
    logic [NUM_REQ-1:0]            sel_oh;
    logic                          sel_read;
    logic [DEV_ADDR_WIDTH-1:0]     sel_dev;
    logic [DEV_REG_ADDR_WIDTH-1:0] sel_reg;
    logic [DATA_WIDTH-1:0]         sel_wr;
    logic [PTR_W-1:0]              sel_next_ptr;

    always_comb begin
        sel_found    = 1'b0;
        sel_k        = 0;
        sel_oh       = '0;
        sel_read     = 1'b0;
        sel_dev      = '0;
        sel_reg      = '0;
        sel_wr       = '0;
        sel_next_ptr = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!sel_found && req_i[k] && (PTR_W'(k) >= ptr)) begin
                sel_found = 1'b1;
                sel_k     = k;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!sel_found && req_i[k]) begin
                sel_found = 1'b1;
                sel_k     = k;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (sel_found && (sel_k == k)) begin
                sel_oh[k]    = 1'b1;
                sel_read     = req_read_i[k];
                sel_dev      = req_dev_addr_i[k*DEV_ADDR_WIDTH +: DEV_ADDR_WIDTH];
                sel_reg      = req_dev_reg_addr_i[k*DEV_REG_ADDR_WIDTH +: DEV_REG_ADDR_WIDTH];
                sel_wr       = req_wr_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                sel_next_ptr = (k == NUM_REQ - 1) ? '0 : PTR_W'(k + 1);
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    // Down-counter loaded on the way into WAIT_BUSY; hitting zero on the
    // last allowed wait cycle means the watchdog has expired.
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;

    assign to_hit = (to_cnt == '0);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= S_IDLE;
            ptr            <= '0;
            owner          <= '0;
            ack_o          <= '0;
            done_o         <= '0;
            read_data_o    <= '0;
            start_trans_o  <= 1'b0;
            read_o         <= 1'b0;
            dev_addr_o     <= '0;
            dev_reg_addr_o <= '0;
            wr_data_o      <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            error_o        <= 1'b0;
            to_cnt         <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done_o <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
                    error_o <= 1'b0;
`endif
                    if (!busy_i && sel_found) begin
                        state          <= S_ISSUE;
                        ptr            <= sel_next_ptr;
                        owner          <= sel_oh;
                        ack_o          <= sel_oh;
                        start_trans_o  <= 1'b1;
                        read_o         <= sel_read;
                        dev_addr_o     <= sel_dev;
                        dev_reg_addr_o <= sel_reg;
                        wr_data_o      <= sel_wr;
                    end
                end
                S_ISSUE: begin
                    ack_o         <= '0;
                    start_trans_o <= 1'b0;
                    state         <= S_WAIT_BUSY;
`ifdef I2C_ARB_TIMEOUT_EN
                    to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
`endif
                end
                S_WAIT_BUSY: begin
`ifdef I2C_ARB_TIMEOUT_EN
                    to_cnt <= to_cnt - 1'b1;
                    if (to_hit) begin
                        state   <= S_DONE;
                        done_o  <= owner;
                        error_o <= 1'b1;
                    end else if (busy_i) begin
                        state <= S_WAIT_DONE;
                    end
`else
                    if (busy_i) begin
                        state <= S_WAIT_DONE;
                    end
`endif
                end
                S_WAIT_DONE: begin
`ifdef I2C_ARB_TIMEOUT_EN
                    to_cnt <= to_cnt - 1'b1;
`endif
                    // A real completion wins over a watchdog expiring in
                    // the same cycle.
                    if (!busy_i) begin
                        state  <= S_DONE;
                        done_o <= owner;
                        if (read_o) begin
                            read_data_o <= read_data_i;
                        end
`ifdef I2C_ARB_TIMEOUT_EN
                    end else if (to_hit) begin
                        state   <= S_DONE;
                        done_o  <= owner;
                        error_o <= 1'b1;
`endif
                    end
                end
                S_DONE: begin
                    done_o <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
                    error_o <= 1'b0;
`endif
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifndef I2C_ARB_TIMEOUT_EN
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_master_arbiter.sv
module tb_i2c_master_arbiter;

    logic        tb_clk = 1'b0;
    logic        rst;
    logic [3:0]  req_i;
    logic [3:0]  req_read_i;
    logic [27:0] req_dev_addr_i;
    logic [31:0] req_dev_reg_addr_i;
    logic [31:0] req_wr_data_i;
    logic [3:0]  ack_o;
    logic [3:0]  done_o;
    logic [7:0]  read_data_o;
    logic        error_o;
    logic        start_trans_o;
    logic        read_o;
    logic [6:0]  dev_addr_o;
    logic [7:0]  dev_reg_addr_o;
    logic [7:0]  wr_data_o;
    logic [7:0]  read_data_i;
    logic        busy_i;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 tb_clk = ~tb_clk;

    i2c_master_arbiter #(
        .NUM_REQ(4),
        .DEV_ADDR_WIDTH(7),
        .DEV_REG_ADDR_WIDTH(8),
        .DATA_WIDTH(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(tb_clk),
        .rst_i(rst),
        .req_i(req_i),
        .req_read_i(req_read_i),
        .req_dev_addr_i(req_dev_addr_i),
        .req_dev_reg_addr_i(req_dev_reg_addr_i),
        .req_wr_data_i(req_wr_data_i),
        .ack_o(ack_o),
        .done_o(done_o),
        .read_data_o(read_data_o),
        .error_o(error_o),
        .start_trans_o(start_trans_o),
        .read_o(read_o),
        .dev_addr_o(dev_addr_o),
        .dev_reg_addr_o(dev_reg_addr_o),
        .wr_data_o(wr_data_o),
        .read_data_i(read_data_i),
        .busy_i(busy_i)
    );

    // Per-requester command contents (constant for the whole run)
    logic [6:0] cmd_dev [4] = '{7'h55, 7'h12, 7'h3C, 7'h7F};
    logic [7:0] cmd_reg [4] = '{8'hAA, 8'h34, 8'h10, 8'h01};
    logic [7:0] cmd_wr  [4] = '{8'hFF, 8'h56, 8'h99, 8'hA5};

    typedef struct {
        logic [3:0] req;
        logic [3:0] rd;
        int         win;
        logic [7:0] rdval;
        logic [7:0] erdata;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},   32'(ack_o), 0);
        chk({tag, "_done"},  32'(done_o), 0);
        chk({tag, "_start"}, 32'(start_trans_o), 0);
        chk({tag, "_read"},  32'(read_o), 0);
        chk({tag, "_dev"},   32'(dev_addr_o), 0);
        chk({tag, "_reg"},   32'(dev_reg_addr_o), 0);
        chk({tag, "_wr"},    32'(wr_data_o), 0);
        chk({tag, "_rdata"}, 32'(read_data_o), 0);
        chk({tag, "_err"},   32'(error_o), 0);
    endtask

    // One full transaction; called right after a falling edge with busy_i=0.
    task automatic run_txn(input logic [3:0] req, input logic [3:0] rd, input int w,
                           input logic [7:0] rdval, input logic [7:0] erdata,
                           input logic [3:0] req_after);
        req_i      = req;
        req_read_i = rd;
        @(negedge tb_clk);
        chk("start",   32'(start_trans_o), 1);
        chk("ack",     32'(ack_o), 32'd1 << w);
        chk("dev",     32'(dev_addr_o), 32'(cmd_dev[w]));
        chk("reg",     32'(dev_reg_addr_o), 32'(cmd_reg[w]));
        chk("wr",      32'(wr_data_o), 32'(cmd_wr[w]));
        chk("read",    32'(read_o), 32'(rd[w]));
        req_i  = req_after;
        busy_i = 1'b1;
        @(negedge tb_clk);
        chk("start_1cyc", 32'(start_trans_o), 0);
        chk("ack_1cyc",   32'(ack_o), 0);
        @(negedge tb_clk);
        @(negedge tb_clk);
        chk("hold_dev", 32'(dev_addr_o), 32'(cmd_dev[w]));
        chk("hold_wr",  32'(wr_data_o), 32'(cmd_wr[w]));
        chk("no_early_done", 32'(done_o), 0);
        busy_i      = 1'b0;
        read_data_i = rdval;
        @(negedge tb_clk);
        chk("done",  32'(done_o), 32'd1 << w);
        chk("rdata", 32'(read_data_o), 32'(erdata));
        chk("err",   32'(error_o), 0);
        @(negedge tb_clk);
        chk("done_1cyc", 32'(done_o), 0);
    endtask

    initial begin
        int  seen;
        int  found_at;

        rst         = 1'b1;
        req_i       = '0;
        req_read_i  = '0;
        busy_i      = 1'b0;
        read_data_i = '0;
        for (int k = 0; k < 4; k++) begin
            req_dev_addr_i[k*7 +: 7]     = cmd_dev[k];
            req_dev_reg_addr_i[k*8 +: 8] = cmd_reg[k];
            req_wr_data_i[k*8 +: 8]      = cmd_wr[k];
        end

        vecs[0] = '{req: 4'b0001, rd: 4'b0000, win: 0, rdval: 8'h77, erdata: 8'h00};
        vecs[1] = '{req: 4'b0100, rd: 4'b0100, win: 2, rdval: 8'h5A, erdata: 8'h5A};
        vecs[2] = '{req: 4'b1001, rd: 4'b0000, win: 3, rdval: 8'h33, erdata: 8'h5A};
        vecs[3] = '{req: 4'b1001, rd: 4'b0001, win: 0, rdval: 8'hC3, erdata: 8'hC3};
        vecs[4] = '{req: 4'b0101, rd: 4'b0100, win: 2, rdval: 8'h11, erdata: 8'h11};

        @(negedge tb_clk);
        chk_all_zero("reset");
        @(negedge tb_clk);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            run_txn(vecs[v].req, vecs[v].rd, vecs[v].win, vecs[v].rdval, vecs[v].erdata, 4'b0000);
        end

        // Contention from a fresh pointer: 0,1,2,3,0
        rst = 1'b1;
        @(negedge tb_clk);
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            run_txn(4'b1111, 4'b0000, n % 4, 8'h00, 8'h00, (n == 4) ? 4'b0000 : 4'b1111);
        end

        // Master busy while idle: no grant until it frees up
        busy_i     = 1'b1;
        req_i      = 4'b0010;
        req_read_i = 4'b0010;
        for (int n = 0; n < 5; n++) begin
            @(negedge tb_clk);
            chk("busy_idle_nostart", 32'(start_trans_o), 0);
        end
        busy_i = 1'b0;
        run_txn(4'b0010, 4'b0010, 1, 8'h6B, 8'h6B, 4'b0000);

        // Request withdrawn before any grant
        busy_i = 1'b1;
        req_i  = 4'b0100;
        @(negedge tb_clk);
        @(negedge tb_clk);
        req_i  = 4'b0000;
        busy_i = 1'b0;
        seen = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge tb_clk);
            if (start_trans_o || (ack_o != 0)) seen++;
        end
        chk("dropped_req_no_grant", 32'(seen), 0);

        // Reset in WAIT_DONE
        req_i      = 4'b1000;
        req_read_i = 4'b0000;
        @(negedge tb_clk);
        chk("rst_case_ack", 32'(ack_o), 32'b1000);
        req_i  = 4'b0000;
        busy_i = 1'b1;
        @(negedge tb_clk);
        @(negedge tb_clk);
        #2 rst = 1'b1;
        #1 chk_all_zero("midrst");
        @(negedge tb_clk);
        rst    = 1'b0;
        busy_i = 1'b0;
        seen   = 0;
        for (int n = 0; n < 2; n++) begin
            @(negedge tb_clk);
            if (done_o != 0) seen++;
        end
        chk("no_spurious_done", 32'(seen), 0);
        run_txn(4'b1000, 4'b0000, 3, 8'hEE, 8'h00, 4'b0000);

        // Master stuck busy
        req_i      = 4'b0001;
        req_read_i = 4'b0001;
        @(negedge tb_clk);
        chk("stuck_start", 32'(start_trans_o), 1);
        req_i  = 4'b0000;
        busy_i = 1'b1;
        found_at = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge tb_clk);
            if (done_o != 0) begin
                found_at = n;
                break;
            end
        end
`ifdef I2C_ARB_TIMEOUT_EN
        // first sample after ISSUE is the WAIT_BUSY entry cycle (n=1)
        chk("timeout_latency", 32'(found_at), 17);
        chk("timeout_done",    32'(done_o), 32'b0001);
        chk("timeout_err",     32'(error_o), 1);
        chk("timeout_rdata",   32'(read_data_o), 0);
        @(negedge tb_clk);
        chk("timeout_err_1cyc", 32'(error_o), 0);
`else
        chk("stuck_no_done", 32'(found_at), 0);
        chk("stuck_no_err",  32'(error_o), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_master_arbiter.md
I2C_MASTER_ARBITER -- requirements
Module: i2c_master_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DEV_ADDR_WIDTH, default 7, I2C device address width.
REQ-003 SHALL have parameter DEV_REG_ADDR_WIDTH, default 8, device register address width.
REQ-004 SHALL have parameter DATA_WIDTH, default 8, data width.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 65535, watchdog limit in clk_i cycles (used only with I2C_ARB_TIMEOUT_EN).
REQ-006 SHALL have clk_i  input  1  single system clock; all logic on its rising edge.
REQ-007 SHALL have rst_i  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have req_i  input  NUM_REQ  per-requester transaction request, level.
REQ-009 SHALL have req_read_i  input  NUM_REQ  per-requester 1=read, 0=write.
REQ-010 SHALL have req_dev_addr_i  input  NUM_REQ*DEV_ADDR_WIDTH  packed device addresses; requester k at slice k.
REQ-011 SHALL have req_dev_reg_addr_i  input  NUM_REQ*DEV_REG_ADDR_WIDTH  packed register addresses.
REQ-012 SHALL have req_wr_data_i  input  NUM_REQ*DATA_WIDTH  packed write data.
REQ-013 SHALL have ack_o  output  NUM_REQ  one-cycle pulse: command of requester k captured.
REQ-014 SHALL have done_o  output  NUM_REQ  one-cycle pulse: transaction of requester k finished.
REQ-015 SHALL have read_data_o  output  DATA_WIDTH  read data, valid in the done_o cycle, held until next done.
REQ-016 SHALL have error_o  output  1  one-cycle pulse coincident with done_o when the transaction timed out.
REQ-017 SHALL have start_trans_o, read_o, dev_addr_o, dev_reg_addr_o, wr_data_o  outputs  1/1/DEV_ADDR_WIDTH/DEV_REG_ADDR_WIDTH/DATA_WIDTH  to the I2C master command port.
REQ-018 SHALL have read_data_i  input  DATA_WIDTH and busy_i  input  1  from the I2C master.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE; all outputs registered.
REQ-020 IDLE: when busy_i=0 and any req_i bit set, SHALL select winner by round-robin from pointer, capture its command, go to ISSUE next cycle; if busy_i=1, SHALL not grant.
REQ-021 Round-robin: search starts at pointer; after grant pointer SHALL become winner+1 modulo NUM_REQ.
REQ-022 ISSUE: SHALL assert start_trans_o and ack_o[winner] for exactly one cycle with captured command on dev_addr_o/dev_reg_addr_o/wr_data_o/read_o; then WAIT_BUSY.
REQ-023 Command outputs SHALL hold captured values from ISSUE through DONE; requester may drop req_i or change command after ack_o.
REQ-024 WAIT_BUSY: SHALL wait for busy_i=1, then WAIT_DONE.
REQ-025 WAIT_DONE: on busy_i=0 SHALL capture read_data_i into read_data_o if read_o=1 (else hold previous), go to DONE.
REQ-026 DONE: SHALL pulse done_o[winner] for one cycle, return to IDLE; new grant possible in the following IDLE cycle.
REQ-027 req_i dropped before ack_o SHALL produce no transaction for that requester.
REQ-028 Latency: req_i sampled in IDLE -> ack_o/start_trans_o on the next cycle.
REQ-029 At most one ack_o bit and one done_o bit SHALL be high in any cycle.

Reset
REQ-030 rst_i=1 SHALL immediately force state IDLE, pointer 0, and all outputs (incl. read_data_o) to 0, including mid-transaction.
REQ-031 First cycle after reset release SHALL behave as IDLE with requester 0 highest priority.

Configuration
REQ-032 Macro I2C_ARB_TIMEOUT_EN defined: counter cleared on entering WAIT_BUSY, counts in WAIT_BUSY/WAIT_DONE; reaching TIMEOUT_CYCLES SHALL go to DONE with error_o=1, read_data_o unchanged.
REQ-033 Macro undefined: no counter, WAIT_BUSY/WAIT_DONE wait indefinitely, error_o tied 0.

Verification
REQ-034 Single write: req_i=0001, dev 0x55, reg 0xAA, data 0xFF -> next cycle start_trans_o=1, ack_o=0001, outputs 0x55/0xAA/0xFF, read_o=0; done_o=0001 after busy_i falls.
REQ-035 Read: req 2 read dev 0x3C reg 0x10, model returns 0x5A -> done_o=0100, read_data_o=0x5A same cycle.
REQ-036 Contention: req_i=1111 held -> grant order 0,1,2,3,0; never two ack_o bits.
REQ-037 busy_i=1 externally in IDLE with req_i=0010 -> no start_trans_o until busy_i=0, then grant next cycle.
REQ-038 Reset asserted in WAIT_DONE -> all outputs 0 at once; after release req_i=1000 served without spurious done_o.
REQ-039 With I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, busy_i stuck 1 -> done_o and error_o pulse 16 cycles after WAIT_BUSY entry; without macro, no done_o.
